puf_eval_controller: RTL and testbench

//  Upstream/downstream controller for the 8-bit arbiter PUF array.
//  - Supplies challenge and launch pulse; samples raw response NUM_EVAL times.
//  - Majority-votes each bit; flags bits that never flipped.
//  - Delivers one voted response word over a valid/ready handshake.
//  - Challenge source: external word, or internal LFSR for enrollment sweeps.

---
 rtl/puf_eval_controller.sv | 158 +++++++++++++++
 tb/tb_puf_eval_controller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_controller.sv
// puf_eval_controller: drives challenge/launch pulses into an 8-bit arbiter PUF,
// majority-votes NUM_EVAL synchronized samples per bit and hands the voted
// word plus a per-bit stability mask to a valid/ready consumer.
module puf_eval_controller #(
  parameter int unsigned NUM_EVAL   = 7,
  parameter int unsigned SETTLE_CYC = 4,
  parameter logic [7:0]  LFSR_SEED  = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       use_lfsr,
  input  logic [7:0] challenge_in,
  output logic       puf_pulse,
  output logic [7:0] puf_challenge,
  input  logic [7:0] puf_response,
  output logic [7:0] resp_out,
  output logic [7:0] stable_mask,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       busy
);

  localparam int unsigned NB = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned PW = $clog2(SETTLE_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PRE,
    S_HIGH,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [CW-1:0]   eval_q, eval_d;
  logic [CW-1:0]   ones_q [NB];
  logic [CW-1:0]   ones_d [NB];
  logic [7:0]      lfsr_q, lfsr_d;
  logic            used_lfsr_q, used_lfsr_d;
  logic [7:0]      chal_d;
  logic            pulse_d;
  logic [7:0]      resp_d, mask_d;
  logic            valid_d;
  logic            busy_d;
  logic [7:0]      sync1_q, sync2_q;

  // Two-flop synchronizer for the asynchronous PUF response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= puf_response;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counter and output computation.
  always_comb begin
    state_d     = state_q;
    phase_d     = '0;
    eval_d      = eval_q;
    ones_d      = ones_q;
    lfsr_d      = lfsr_q;
    used_lfsr_d = used_lfsr_q;
    chal_d      = puf_challenge;
    resp_d      = resp_out;
    mask_d      = stable_mask;
    valid_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          chal_d      = use_lfsr ? lfsr_q : challenge_in;
          used_lfsr_d = use_lfsr;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        eval_d = '0;
        for (int i = 0; i < NB; i++) ones_d[i] = '0;
        state_d = S_PRE;
      end
      S_PRE: begin
        if (phase_q == PW'(SETTLE_CYC - 1)) state_d = S_HIGH;
        else phase_d = phase_q + PW'(1);
      end
      S_HIGH: begin
        if (phase_q == PW'(SETTLE_CYC - 1)) state_d = S_SAMPLE;
        else phase_d = phase_q + PW'(1);
      end
      S_SAMPLE: begin
        for (int i = 0; i < NB; i++) ones_d[i] = ones_q[i] + CW'(sync2_q[i]);
        eval_d = eval_q + CW'(1);
        if (eval_q == CW'(NUM_EVAL - 1)) begin
          // Vote on the updated counts so the result lands with resp_valid.
          for (int i = 0; i < NB; i++) begin
            resp_d[i] = ones_d[i] > CW'(NUM_EVAL / 2);
            mask_d[i] = (ones_d[i] == '0) || (ones_d[i] == CW'(NUM_EVAL));
          end
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_PRE;
        end
      end
      S_DONE: begin
        valid_d = 1'b1;
        if (resp_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
          if (used_lfsr_q)
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
      end
      default: state_d = S_IDLE;
    endcase

    pulse_d = (state_d == S_HIGH) || (state_d == S_SAMPLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      phase_q       <= '0;
      eval_q        <= '0;
      for (int i = 0; i < NB; i++) ones_q[i] <= '0;
      lfsr_q        <= LFSR_SEED;
      used_lfsr_q   <= 1'b0;
      puf_challenge <= '0;
      puf_pulse     <= 1'b0;
      resp_out      <= '0;
      stable_mask   <= '0;
      resp_valid    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      eval_q        <= eval_d;
      ones_q        <= ones_d;
      lfsr_q        <= lfsr_d;
      used_lfsr_q   <= used_lfsr_d;
      puf_challenge <= chal_d;
      puf_pulse     <= pulse_d;
      resp_out      <= resp_d;
      stable_mask   <= mask_d;
      resp_valid    <= valid_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_puf_eval_controller.sv
// Directed bench for puf_eval_controller: reset, stable and noisy PUF
// responses, LFSR challenge sequence, backpressure and mid-run reset.
module tb_puf_eval_controller;

  localparam int SETTLE  = 4;
  localparam int NEVAL   = 7;
  localparam int LATENCY = 1 + NEVAL * (2 * SETTLE + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       use_lfsr;
  logic [7:0] challenge_in;
  logic       puf_pulse;
  logic [7:0] puf_challenge;
  logic [7:0] puf_response;
  logic [7:0] resp_out;
  logic [7:0] stable_mask;
  logic       resp_valid;
  logic       resp_ready;
  logic       busy;

  int checks = 0;
  int passed = 0;
  logic [7:0] pat [NEVAL];

  puf_eval_controller #(.NUM_EVAL(NEVAL), .SETTLE_CYC(SETTLE), .LFSR_SEED(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .use_lfsr(use_lfsr),
    .challenge_in(challenge_in), .puf_pulse(puf_pulse), .puf_challenge(puf_challenge),
    .puf_response(puf_response), .resp_out(resp_out), .stable_mask(stable_mask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Starts one evaluation and plays the PUF model until resp_valid or timeout.
  task automatic run_eval(input logic [7:0] chal, input logic lfsr,
                          output int lat, output int rises, output int bad,
                          output logic [7:0] chal_seen);
    logic prev;
    int hi, lo, idx;
    bit done;
    start = 1'b1; use_lfsr = lfsr; challenge_in = chal;
    @(negedge clk);
    start = 1'b0;
    lat = 0; rises = 0; bad = 0; hi = 0; lo = 0; idx = 0; done = 0;
    prev = puf_pulse;
    chal_seen = puf_challenge;
    while (lat < 300 && !done) begin
      @(negedge clk);
      lat++;
      if (puf_challenge !== chal_seen) bad++;
      if (puf_pulse && !prev) begin
        rises++;
        if (rises > 1 && lo != SETTLE) bad++;
        hi = 1;
        puf_response = pat[(idx < NEVAL) ? idx : NEVAL - 1];
        idx++;
      end else if (!puf_pulse && prev) begin
        if (hi != SETTLE + 1) bad++;
        lo = 1;
      end else if (puf_pulse) begin
        hi++;
      end else begin
        lo++;
      end
      prev = puf_pulse;
      if (resp_valid) done = 1;
    end
    if (!done) lat = -1;
  endtask

  task automatic handoff(input logic [7:0] exp_resp);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL handoff: valid=%b busy=%b required 0 0", resp_valid, busy);
    else passed++;
    checks++; if (resp_out !== exp_resp)
      $display("FAIL hold_resp: resp_out=%h required %h", resp_out, exp_resp);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; use_lfsr = 1'b0; challenge_in = '0;
    puf_response = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({puf_pulse, puf_challenge, resp_out, stable_mask, resp_valid, busy} !== 27'd0)
      $display("FAIL reset_outputs: pulse=%b chal=%h resp=%h mask=%h valid=%b busy=%b required all 0",
               puf_pulse, puf_challenge, resp_out, stable_mask, resp_valid, busy);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stable();
    int lat, rises, bad; logic [7:0] cs;
    for (int k = 0; k < NEVAL; k++) pat[k] = 8'hA5;
    run_eval(8'h3C, 1'b0, lat, rises, bad, cs);
    checks++; if (lat !== LATENCY) $display("FAIL stable_latency: got %0d required %0d", lat, LATENCY); else passed++;
    checks++; if (puf_challenge !== 8'h3C) $display("FAIL stable_chal: got %h required 3c", puf_challenge); else passed++;
    checks++; if (resp_out !== 8'hA5) $display("FAIL stable_resp: got %h required a5", resp_out); else passed++;
    checks++; if (stable_mask !== 8'hFF) $display("FAIL stable_mask: got %h required ff", stable_mask); else passed++;
    checks++; if (rises !== NEVAL || bad !== 0)
      $display("FAIL stable_pulses: rises=%0d bad=%0d required %0d 0", rises, bad, NEVAL);
    else passed++;
    handoff(8'hA5);
  endtask

  task automatic test_noisy();
    int lat, rises, bad; logic [7:0] cs;
    pat[0] = 8'h03; pat[1] = 8'h03; pat[2] = 8'h03; pat[3] = 8'h01;
    pat[4] = 8'h00; pat[5] = 8'h00; pat[6] = 8'h00;
    run_eval(8'h00, 1'b0, lat, rises, bad, cs);
    checks++; if (lat !== LATENCY) $display("FAIL noisy_latency: got %0d required %0d", lat, LATENCY); else passed++;
    checks++; if (resp_out !== 8'h01) $display("FAIL noisy_resp: got %h required 01", resp_out); else passed++;
    checks++; if (stable_mask !== 8'hFC) $display("FAIL noisy_mask: got %h required fc", stable_mask); else passed++;
    handoff(8'h01);
  endtask

  task automatic test_back_to_back_lfsr();
    int lat, rises, bad; logic [7:0] cs;
    logic [7:0] exp_chal [3];
    exp_chal[0] = 8'h01; exp_chal[1] = 8'h02; exp_chal[2] = 8'h04;
    for (int k = 0; k < NEVAL; k++) pat[k] = 8'h5A;
    for (int r = 0; r < 3; r++) begin
      run_eval(8'hFF, 1'b1, lat, rises, bad, cs);
      checks++; if (puf_challenge !== exp_chal[r])
        $display("FAIL lfsr_chal run%0d: got %h required %h", r, puf_challenge, exp_chal[r]);
      else passed++;
      checks++; if (rises !== NEVAL || bad !== 0 || lat !== LATENCY)
        $display("FAIL lfsr_pulses run%0d: rises=%0d bad=%0d lat=%0d required %0d 0 %0d",
                 r, rises, bad, lat, NEVAL, LATENCY);
      else passed++;
      handoff(8'h5A);
    end
  endtask

  task automatic test_backpressure();
    int lat, rises, bad, unstable; logic [7:0] cs;
    for (int k = 0; k < NEVAL; k++) pat[k] = 8'hC3;
    run_eval(8'h77, 1'b0, lat, rises, bad, cs);
    unstable = 0;
    for (int c = 0; c < 20; c++) begin
      start = (c % 3 == 0);
      @(negedge clk);
      if (resp_out !== 8'hC3 || stable_mask !== 8'hFF || resp_valid !== 1'b1 ||
          busy !== 1'b1 || puf_pulse !== 1'b0 || puf_challenge !== 8'h77) unstable++;
    end
    checks++; if (unstable !== 0) $display("FAIL bp_hold: %0d unstable cycles required 0", unstable); else passed++;
    start = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL bp_handoff: valid=%b busy=%b required 0 0", resp_valid, busy);
    else passed++;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL bp_start_ignored: busy=%b required 0", busy); else passed++;
  endtask

  task automatic test_midrun_reset();
    int rises, n, lat, bad; logic prev; logic [7:0] cs;
    start = 1'b1; use_lfsr = 1'b0; challenge_in = 8'h99;
    @(negedge clk);
    start = 1'b0;
    rises = 0; n = 0; prev = puf_pulse;
    while (rises < 3 && n < 200) begin
      @(negedge clk); n++;
      if (puf_pulse && !prev) rises++;
      prev = puf_pulse;
    end
    checks++; if (rises !== 3 || puf_pulse !== 1'b1)
      $display("FAIL rst_reach_high: rises=%0d pulse=%b required 3 1", rises, puf_pulse);
    else passed++;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (puf_pulse !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0 || resp_out !== 8'h00)
      $display("FAIL rst_midrun: pulse=%b busy=%b valid=%b resp=%h required 0 0 0 00",
               puf_pulse, busy, resp_valid, resp_out);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NEVAL; k++) pat[k] = 8'h6E;
    run_eval(8'h5A, 1'b0, lat, rises, bad, cs);
    checks++; if (lat !== LATENCY || resp_out !== 8'h6E || stable_mask !== 8'hFF || puf_challenge !== 8'h5A)
      $display("FAIL rst_rerun: lat=%0d resp=%h mask=%h chal=%h required %0d 6e ff 5a",
               lat, resp_out, stable_mask, puf_challenge, LATENCY);
    else passed++;
    handoff(8'h6E);
  endtask

  initial begin
    test_reset();
    test_stable();
    test_noisy();
    test_back_to_back_lfsr();
    test_backpressure();
    test_midrun_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
